// File: rtl/dmem_mmio_pkg.sv
// Shared constants for the data-side memory slave: address regions, MMIO
// register offsets and timer control bit positions.
package dmem_mmio_pkg;

  localparam logic [3:0] REGION_RAM  = 4'h0;
  localparam logic [3:0] REGION_MMIO = 4'h4;

  localparam logic [1:0] OFF_GPIO   = 2'd0;
  localparam logic [1:0] OFF_TCOUNT = 2'd1;
  localparam logic [1:0] OFF_TCMP   = 2'd2;
  localparam logic [1:0] OFF_TCTRL  = 2'd3;

  localparam int TCTRL_EN   = 0;
  localparam int TCTRL_FLAG = 1;
  localparam int TCTRL_AUTO = 2;

endpackage

// File: rtl/dmem_mmio_timer.sv
// Memory-mapped 32-bit timer: counter, compare, control with sticky W1C flag
// and optional auto-reload on match.
module mmio_timer
  import dmem_mmio_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  wr_en,
  input  logic [1:0]            offset,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] count;
  logic [DATA_WIDTH-1:0] cmp;
  logic                  en;
  logic                  auto;
  logic                  flag;
  logic                  match;
  logic                  wr_count;
  logic                  wr_cmp;
  logic                  wr_ctrl;

  assign match    = en && (count == cmp);
  assign wr_count = wr_en && (offset == OFF_TCOUNT);
  assign wr_cmp   = wr_en && (offset == OFF_TCMP);
  assign wr_ctrl  = wr_en && (offset == OFF_TCTRL);

  // A software load of the counter beats both increment and auto-reload.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count <= '0;
    end else if (wr_count) begin
      count <= write_data;
    end else if (en) begin
      if (match && auto) count <= '0;
      else               count <= count + DATA_WIDTH'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cmp  <= '0;
      en   <= 1'b0;
      auto <= 1'b0;
    end else begin
      if (wr_cmp) cmp <= write_data;
      if (wr_ctrl) begin
        en   <= write_data[TCTRL_EN];
        auto <= write_data[TCTRL_AUTO];
      end
    end
  end

  // A hardware set in the same cycle as a W1C leaves the flag high.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      flag <= 1'b0;
    end else if (match) begin
      flag <= 1'b1;
    end else if (wr_ctrl && write_data[TCTRL_FLAG]) begin
      flag <= 1'b0;
    end
  end

  always_comb begin
    read_data = '0;
    case (offset)
      OFF_TCOUNT: read_data = count;
      OFF_TCMP:   read_data = cmp;
      OFF_TCTRL: begin
        read_data[TCTRL_EN]   = en;
        read_data[TCTRL_FLAG] = flag;
        read_data[TCTRL_AUTO] = auto;
      end
      default:    read_data = '0;
    endcase
  end

  assign irq = flag;

endmodule

// File: rtl/dmem_mmio.sv
// Data-side slave of the single-cycle core: word RAM, GPIO register and timer
// behind a combinational, zero-latency read path.
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int RAM_DEPTH     = 64,
  parameter int RAM_ADDR_BITS = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [31:0]           addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  mem_write,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic [DATA_WIDTH-1:0] gpio_out,
  output logic                  timer_irq
);

  logic [DATA_WIDTH-1:0]    ram [RAM_DEPTH];
  logic [RAM_ADDR_BITS-1:0] ram_index;
  logic [1:0]               offset;
  logic                     ram_sel;
  logic                     mmio_sel;
  logic [DATA_WIDTH-1:0]    timer_read;
  logic                     unused_addr;

  assign ram_index   = addr[RAM_ADDR_BITS+1:2];
  assign offset      = addr[3:2];
  assign ram_sel     = (addr[31:28] == REGION_RAM);
  assign mmio_sel    = (addr[31:28] == REGION_MMIO);
  assign unused_addr = ^{addr[27:RAM_ADDR_BITS+2], addr[1:0]};

  // Reset clears every RAM word, so the array lives in flops rather than a macro.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < RAM_DEPTH; i++) ram[i] <= '0;
    end else if (mem_write && ram_sel) begin
      ram[ram_index] <= write_data;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      gpio_out <= '0;
    end else if (mem_write && mmio_sel && (offset == OFF_GPIO)) begin
      gpio_out <= write_data;
    end
  end

  mmio_timer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_timer (
    .CLK        (CLK),
    .RST        (RST),
    .wr_en      (mem_write && mmio_sel),
    .offset     (offset),
    .write_data (write_data),
    .read_data  (timer_read),
    .irq        (timer_irq)
  );

  always_comb begin
    read_data = '0;
    if (ram_sel) begin
      read_data = ram[ram_index];
    end else if (mmio_sel) begin
      if (offset == OFF_GPIO) read_data = gpio_out;
      else                    read_data = timer_read;
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: a reference memory/timer model checked
// every cycle, plus directed scenarios with literal expected values.
module tb_dmem_mmio;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] write_data = '0;
  logic        mem_write = 1'b0;
  logic [31:0] read_data;
  logic [31:0] gpio_out;
  logic        timer_irq;

  int total_checks  = 0;
  int passed_checks = 0;
  bit checking      = 1'b0;

  dmem_mmio dut (
    .CLK        (CLK),
    .RST        (RST),
    .addr       (addr),
    .write_data (write_data),
    .mem_write  (mem_write),
    .read_data  (read_data),
    .gpio_out   (gpio_out),
    .timer_irq  (timer_irq)
  );

  always #5 CLK = ~CLK;

  // Reference model state
  logic [31:0] m_ram [64];
  logic [31:0] m_gpio, m_count, m_cmp, m_next_count;
  bit          m_en, m_auto, m_flag, m_next_flag, m_hit;

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] r;
    r = 32'h0;
    if (a[31:28] == 4'h0) r = m_ram[a[7:2]];
    else if (a[31:28] == 4'h4) begin
      case (a[3:2])
        2'd0: r = m_gpio;
        2'd1: r = m_count;
        2'd2: r = m_cmp;
        default: r = {29'h0, m_auto, m_flag, m_en};
      endcase
    end
    return r;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 64; i++) m_ram[i] = 32'h0;
      m_gpio = 0; m_count = 0; m_cmp = 0; m_en = 0; m_auto = 0; m_flag = 0;
    end else begin
      m_hit        = m_en && (m_count == m_cmp);
      m_next_count = m_count;
      m_next_flag  = m_flag || m_hit;
      if (m_en) m_next_count = (m_hit && m_auto) ? 32'h0 : m_count + 32'h1;
      if (mem_write && addr[31:28] == 4'h0) m_ram[addr[7:2]] = write_data;
      if (mem_write && addr[31:28] == 4'h4) begin
        case (addr[3:2])
          2'd0: m_gpio = write_data;
          2'd1: m_next_count = write_data;
          2'd2: m_cmp = write_data;
          default: begin
            m_en   = write_data[0];
            m_auto = write_data[2];
            if (write_data[1] && !m_hit) m_next_flag = 0;
          end
        endcase
      end
      m_count = m_next_count;
      m_flag  = m_next_flag;
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_checks++;
    if (act === exp) passed_checks++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge CLK) begin
    if (checking && !RST) begin
      check_output("cycle read_data", read_data, model_read(addr));
      check_output("cycle gpio_out", gpio_out, m_gpio);
      check_output("cycle timer_irq", {31'h0, timer_irq}, {31'h0, m_flag});
    end
  end

  task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] wd, input logic we);
    @(posedge CLK);
    #2;
    addr       = a;
    write_data = wd;
    mem_write  = we;
  endtask

  task automatic read_and_check(input string name, input logic [31:0] a,
                                input logic [31:0] exp, input logic exp_irq);
    apply_stimulus(a, 32'h0, 1'b0);
    #1;
    check_output(name, read_data, exp);
    check_output({name, " irq"}, {31'h0, timer_irq}, {31'h0, exp_irq});
  endtask

  localparam logic [31:0] GPIO   = 32'h4000_0000;
  localparam logic [31:0] TCOUNT = 32'h4000_0004;
  localparam logic [31:0] TCMP   = 32'h4000_0008;
  localparam logic [31:0] TCTRL  = 32'h4000_000C;

  initial begin
    repeat (2) @(posedge CLK);
    #2 RST = 1'b0;
    checking = 1'b1;
    #1 check_output("reset read_data", read_data, 32'h0);
    check_output("reset gpio_out", gpio_out, 32'h0);
    check_output("reset timer_irq", {31'h0, timer_irq}, 32'h0);

    $display("[TB] RAM store/load and aliasing");
    apply_stimulus(32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
    #1 check_output("ram old value during store", read_data, 32'h0);
    read_and_check("ram load", 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
    read_and_check("ram alias", 32'h0000_0110, 32'hDEAD_BEEF, 1'b0);
    read_and_check("ram low bits", 32'h0000_0013, 32'hDEAD_BEEF, 1'b0);

    $display("[TB] asynchronous reset mid-run");
    apply_stimulus(32'h0000_0014, 32'h0000_1234, 1'b1);
    apply_stimulus(GPIO, 32'h0000_00A5, 1'b1);
    read_and_check("gpio readback", GPIO, 32'h0000_00A5, 1'b0);
    read_and_check("ram5 before reset", 32'h0000_0014, 32'h0000_1234, 1'b0);
    RST = 1'b1;
    #1 check_output("async reset read_data", read_data, 32'h0);
    check_output("async reset gpio_out", gpio_out, 32'h0);
    check_output("async reset timer_irq", {31'h0, timer_irq}, 32'h0);
    RST = 1'b0;
    read_and_check("ram5 after reset", 32'h0000_0014, 32'h0, 1'b0);

    $display("[TB] timer one-shot");
    apply_stimulus(TCMP, 32'd5, 1'b1);
    apply_stimulus(TCOUNT, 32'd0, 1'b1);
    apply_stimulus(TCTRL, 32'h1, 1'b1);
    for (int i = 0; i < 9; i++)
      read_and_check("oneshot count", TCOUNT, 32'(i), i >= 6);
    apply_stimulus(TCTRL, 32'h3, 1'b1);
    read_and_check("w1c count", TCOUNT, 32'd10, 1'b0);

    $display("[TB] timer auto-reload");
    apply_stimulus(TCTRL, 32'h0, 1'b1);
    apply_stimulus(TCMP, 32'd3, 1'b1);
    apply_stimulus(TCOUNT, 32'd0, 1'b1);
    apply_stimulus(TCTRL, 32'h5, 1'b1);
    for (int i = 0; i < 9; i++)
      read_and_check("auto count", TCOUNT, 32'(i % 4), i >= 4);

    $display("[TB] counter wrap");
    apply_stimulus(TCTRL, 32'h0, 1'b1);
    apply_stimulus(TCTRL, 32'h2, 1'b1);
    apply_stimulus(TCMP, 32'h10, 1'b1);
    apply_stimulus(TCOUNT, 32'hFFFF_FFFE, 1'b1);
    apply_stimulus(TCTRL, 32'h1, 1'b1);
    read_and_check("wrap fe", TCOUNT, 32'hFFFF_FFFE, 1'b0);
    read_and_check("wrap ff", TCOUNT, 32'hFFFF_FFFF, 1'b0);
    read_and_check("wrap 0", TCOUNT, 32'h0, 1'b0);
    read_and_check("wrap 1", TCOUNT, 32'h1, 1'b0);

    $display("[TB] counter write during match");
    apply_stimulus(TCTRL, 32'h0, 1'b1);
    apply_stimulus(TCOUNT, 32'd7, 1'b1);
    apply_stimulus(TCMP, 32'd7, 1'b1);
    apply_stimulus(TCTRL, 32'h1, 1'b1);
    apply_stimulus(TCOUNT, 32'h100, 1'b1);
    read_and_check("write beats match", TCOUNT, 32'h100, 1'b1);

    $display("[TB] W1C during match");
    apply_stimulus(TCTRL, 32'h2, 1'b1);
    apply_stimulus(TCOUNT, 32'd9, 1'b1);
    apply_stimulus(TCMP, 32'd9, 1'b1);
    apply_stimulus(TCTRL, 32'h1, 1'b1);
    apply_stimulus(TCTRL, 32'h3, 1'b1);
    #1 check_output("flag clear before match", {31'h0, timer_irq}, 32'h0);
    read_and_check("set beats w1c", TCOUNT, 32'd10, 1'b1);

    $display("[TB] unmapped region");
    apply_stimulus(GPIO, 32'h0000_5A5A, 1'b1);
    apply_stimulus(32'h8000_0000, 32'h55, 1'b1);
    read_and_check("unmapped read", 32'h8000_0000, 32'h0, 1'b1);
    read_and_check("ram0 untouched", 32'h0000_0000, 32'h0, 1'b1);
    read_and_check("gpio untouched", GPIO, 32'h0000_5A5A, 1'b1);
    read_and_check("tctrl readback", TCTRL, 32'h3, 1'b1);
    check_output("tctrl upper bits", {3'h0, read_data[31:3]}, 32'h0);

    @(posedge CLK);
    #2 mem_write = 1'b0;
    repeat (2) @(posedge CLK);
    checking = 1'b0;
    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/dmem_mmio.md
Name: dmem_mmio

Overview:
- Data-side slave of the single-cycle RV32I core.
- Takes the core's ALU address, store data and write-enable, and returns load data in the same cycle.
- Contains a word-addressed data RAM plus a memory-mapped register bank:
  - one GPIO output register;
  - a 32-bit timer with compare, sticky interrupt flag and auto-reload.

Parameters:
- DATA_WIDTH, 32, width of the data bus and of every register.
- RAM_DEPTH, 64, number of 32-bit RAM words (power of two).
- RAM_ADDR_BITS, 6, log2(RAM_DEPTH).

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- addr  input  32  byte address (core ALU result); bits [1:0] ignored.
- write_data  input  32  store data.
- mem_write  input  1  store enable, sampled on the rising CLK edge.
- read_data  output  32  load data, combinational from addr and current state.
- gpio_out  output  32  GPIO register contents.
- timer_irq  output  1  registered copy of the timer flag.

Behaviour:
- Clock and reset:
  - One clock (CLK).
  - RST is asynchronous and active-high.
  - RST high clears: all RAM words, gpio_out, TCOUNT, TCMP, TCTRL, and therefore timer_irq (all outputs 0).
  - Deasserting RST mid-operation resumes from the cleared state on the next edge; there is no other state.
- Address decode (addr[31:28]):
  - 0x0: RAM. Word index = addr[RAM_ADDR_BITS+1:2]. Upper address bits alias.
  - 0x4: MMIO. Offset = addr[3:2]; addr[27:4] ignored.
  - Any other region: reads return 0, writes are ignored.
- Read path:
  - Combinational, zero latency, required by the single-cycle core.
  - A store and a load to the same location in one cycle return the old value.
  - The new value is visible from the cycle after the edge.
- Write path: a write commits on the rising edge when mem_write=1.
- MMIO registers:
  - off 0, GPIO (RW): gpio_out = register.
  - off 1, TCOUNT (RW): a write loads the counter.
  - off 2, TCMP (RW): compare value.
  - off 3, TCTRL:
    - bit0 EN, RW.
    - bit1 FLAG: reads the sticky flag; writing 1 clears it, writing 0 has no effect.
    - bit2 AUTO, RW.
    - bits [31:3] read 0.
- Timer, each edge with EN=1:
  - If TCOUNT==TCMP: FLAG<=1. With AUTO=1, TCOUNT<=0; with AUTO=0, TCOUNT<=TCOUNT+1.
  - Otherwise TCOUNT<=TCOUNT+1, modulo 2^32 (0xFFFFFFFF wraps to 0, no flag from the wrap itself).
- EN=0: the counter holds and no compare is evaluated.
- Priority rules for simultaneous events:
  - A software write to TCOUNT overrides increment and auto-reload in the same cycle.
  - A hardware FLAG set wins over a W1C in the same cycle, so the flag stays 1.
  - A write to TCTRL takes effect on the next cycle's count decision. The cycle of the write uses the old EN and AUTO.
- timer_irq equals FLAG: it rises in the cycle after the matching edge and stays high until cleared.

Decomposition:
- Shared package dmem_mmio_pkg holds:
  - region codes: RAM=4'h0, MMIO=4'h4;
  - MMIO offsets: GPIO=0, TCOUNT=1, TCMP=2, TCTRL=3;
  - TCTRL bit indices: EN=0, FLAG=1, AUTO=2.
- One sub-module, mmio_timer:
  - holds TCOUNT, TCMP and TCTRL, with their write strobes and the compare/flag logic;
  - exports its read value and irq.
- The RAM array, GPIO register and read mux stay in dmem_mmio.

Test Plan:
1. RAM store/load: write 0xDEADBEEF to 0x0000_0010, then load 0x0000_0010 -> 0xDEADBEEF. Load 0x0000_0110 (alias) -> 0xDEADBEEF. Load 0x0000_0013 -> same word.
2. Reset mid-run: fill RAM[5]=0x1234 and GPIO=0xA5, pulse RST asynchronously between edges -> read_data, gpio_out and timer_irq are 0 immediately; RAM[5] reads 0.
3. Timer one-shot: TCMP=5, TCOUNT=0, TCTRL=0x1 -> timer_irq rises the cycle after TCOUNT==5. TCOUNT continues 6, 7, ... Write TCTRL=0x3 (W1C) -> irq drops next cycle.
4. Auto-reload: TCMP=3, TCTRL=0x5 -> TCOUNT sequence is 0,1,2,3,0,1,2,3. FLAG sets on the first match and remains set.
5. Wrap and priority:
   - TCOUNT=0xFFFFFFFE, TCMP=0x10, EN=1 -> counts FFFFFFFF, then 0, with no irq.
   - TCOUNT write of 0x100 in a match cycle -> TCOUNT=0x100.
   - W1C in the same cycle as a match -> FLAG stays 1.
6. Unmapped region: write 0x55 to 0x8000_0000 -> read 0, no RAM/GPIO change. Read of TCTRL upper bits -> 0.
